axi_full_m_refill: RTL and testbench
====================================

# axi_full_m_refill

Read-only AXI4 burst master that refills one cache line on request. Sits between the cache controller and the AXI memory slave: accepts a line-miss address, issues a single INCR read burst of 64-bit beats, assembles the beats into a line buffer and returns the whole line with an error flag in a one-cycle response pulse. One outstanding burst at a time; no write channels.

## Interface
- LINE_BEATS, 4, beats per line (1..256); line size = LINE_BEATS*8 bytes; arlen = LINE_BEATS-1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  cache requests a refill
- req_addr  in  32  miss address (any byte address)
- req_ready  out  1  block idle, request accepted when req_valid&req_ready
- resp_valid  out  1  one-cycle pulse: line complete
- resp_line  out  64*LINE_BEATS  assembled line, beat i at bits [64*i+63 : 64*i]
- resp_err  out  1  valid with resp_valid: any beat had rresp!=0, or a burst-length violation occurred
- araddr  out  32  burst start address, line-aligned
- arvalid  out  1  address valid
- arburst  out  2  constant 2'b01 (INCR)
- arlen  out  8  constant LINE_BEATS-1
- arsize  out  3  constant 3'b011 (8 bytes)
- arready  in  1  slave accepts address
- rdata  in  64  beat data
- rresp  in  2  beat response
- rvalid  in  1  beat valid
- rlast  in  1  final beat
- rready  out  1  master accepts beat

## Operation
- States: IDLE, AR, R, DONE.
- IDLE: req_ready=1. On req_valid: latch araddr = req_addr with low log2(LINE_BEATS*8) bits cleared; clear beat counter and error flag; go AR.
- AR: arvalid=1, araddr stable. On arready: go R. arvalid never deasserts before handshake.
- R: rready=1. Each rvalid&rready beat: write rdata into line slot [cnt]; error |= (rresp!=0); cnt++.
  - Beat with rlast=1 and cnt==LINE_BEATS-1: normal end, go DONE.
  - Beat with rlast=1 and cnt<LINE_BEATS-1 (early rlast): error=1, go DONE; unwritten slots keep previous contents.
  - Beat with cnt==LINE_BEATS-1 and rlast=0 (missing rlast): error=1, go DONE; further beats are not accepted.
- DONE: resp_valid=1, resp_err=error, for exactly one cycle; no backpressure from cache; go IDLE.
- Beats arriving outside R are not accepted (rready=0) and do not alter state.
- resp_line holds its value from DONE until the next beat write of a later burst.
- Counter width 8 bits; never wraps within a burst because exit at cnt==LINE_BEATS-1 is forced.

## Timing
- Reset values: state IDLE, req_ready=1, arvalid=0, rready=0, resp_valid=0, resp_err=0, araddr=0, resp_line=0, counter=0. Constants arburst/arlen/arsize are driven regardless of reset.
- Reset asserted mid-burst: next cycle all outputs at reset values; in-flight beats are dropped; no resp_valid pulse.
- Request accepted cycle T -> arvalid=1 from T+1.
- arready at cycle A -> rready=1 from A+1.
- Last beat at cycle L -> resp_valid=1 at L+1 -> req_ready=1 at L+2.
- Minimum latency, LINE_BEATS=4, arready and rvalid held high: accept T, AR handshake T+1, beats T+2..T+5, resp_valid T+6, next accept T+7.
- req_valid is ignored while req_ready=0; the cache holds or re-presents it.

## Test plan
- Normal: req_addr=0x8000_1234, LINE_BEATS=4, arready=1, beats 0x11..,0x22..,0x33..,0x44.. continuous, rlast on 4th -> araddr=0x8000_1220, arlen=3, arsize=3, arburst=1, resp_valid at T+6, resp_line = {0x44..,0x33..,0x22..,0x11..}, resp_err=0.
- arready held low 3 cycles and rvalid with 2-cycle gaps between beats -> arvalid/araddr stable until handshake, exactly 4 beats captured in order, single resp_valid pulse, resp_err=0.
- rresp=2'b10 on beat 1 only -> all 4 beats stored, resp_err=1.
- Early rlast on beat 2 of 4 -> resp_valid right after beat 2, resp_err=1, slot 3 unchanged from prior line.
- Missing rlast: 4 beats with rlast=0 -> DONE after beat 4, resp_err=1, rready=0 afterwards, 5th rvalid not accepted.
- rst pulsed during beat 2 -> next cycle req_ready=1, arvalid=0, rready=0, no resp_valid; new request then completes normally with resp_err=0.

Source files
------------

// File: rtl/axi_full_m_refill_if.sv
// Bundles the cache-side request/response and the AXI4 read channels of the line refill engine.
interface axi_full_m_refill_if #(
  parameter int LINE_BEATS = 4
);
  // Cache side
  logic                    req_valid;
  logic [31:0]             req_addr;
  logic                    req_ready;
  logic                    resp_valid;
  logic [64*LINE_BEATS-1:0] resp_line;
  logic                    resp_err;

  // AXI read address channel
  logic [31:0]             araddr;
  logic                    arvalid;
  logic [1:0]              arburst;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic                    arready;

  // AXI read data channel
  logic [63:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rlast;
  logic                    rready;

  modport master (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_line, resp_err,
    output araddr, arvalid, arburst, arlen, arsize,
    input  arready,
    input  rdata, rresp, rvalid, rlast,
    output rready
  );

  modport slave (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_line, resp_err,
    input  araddr, arvalid, arburst, arlen, arsize,
    output arready,
    output rdata, rresp, rvalid, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_full_m_refill.sv
// Read-only AXI4 burst master: one INCR burst per cache-line miss, beats gathered
// into a line buffer and returned with an error flag in a single-cycle pulse.
module axi_full_m_refill #(
  parameter int LINE_BEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  axi_full_m_refill_if.master bus
);

  localparam int          OFFSET_BITS = $clog2(LINE_BEATS * 8);
  localparam int          IDX_W       = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [31:0] ADDR_MASK   = ~((32'd1 << OFFSET_BITS) - 32'd1);
  localparam logic [7:0]  LAST_CNT    = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [7:0]  cnt;
  logic        err;
  logic [63:0] line_q [LINE_BEATS];
  logic        beat;
  logic        last_slot;
  logic        beat_end;

  // A beat is taken only while collecting; the burst ends on rlast or when the
  // final slot is filled, whichever comes first, so the counter never wraps.
  assign beat      = (state == R) && bus.rvalid;
  assign last_slot = (cnt == LAST_CNT);
  assign beat_end  = beat && (bus.rlast || last_slot);

  assign bus.araddr  = addr_q;
  assign bus.arburst = 2'b01;
  assign bus.arlen   = LAST_CNT;
  assign bus.arsize  = 3'b011;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection and handshake outputs decoded from the current state
  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = AR;
      end
      AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_next = R;
      end
      R: begin
        bus.rready = 1'b1;
        if (beat_end) state_next = DONE;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the aligned burst address, count beats, store data and accumulate errors;
  // a mismatch between rlast and the final slot marks a burst-length violation
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      for (int i = 0; i < LINE_BEATS; i++) line_q[i] <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr & ADDR_MASK;
        cnt    <= '0;
        err    <= 1'b0;
      end
      if (beat) begin
        line_q[cnt[IDX_W-1:0]] <= bus.rdata;
        cnt <= cnt + 8'd1;
        err <= err | (bus.rresp != 2'b00) | (bus.rlast != last_slot);
      end
    end
  end

  // Flatten the beat slots into the response line, beat i in the i-th 64-bit lane
  always_comb begin
    bus.resp_line = '0;
    for (int i = 0; i < LINE_BEATS; i++) bus.resp_line[64*i +: 64] = line_q[i];
  end

endmodule

// File: tb/tb_axi_full_m_refill.sv
// Self-checking bench for axi_full_m_refill: drives the cache request and acts as the
// AXI memory slave, predicting each returned line and error flag in a scoreboard.
module tb_axi_full_m_refill;

  localparam int LB = 4;

  typedef struct {
    logic [64*LB-1:0] line;
    logic             err;
  } exp_t;

  typedef struct {
    logic [64*LB-1:0] line;
    logic             err;
    int               cyc;
  } resp_t;

  logic clk;
  logic rst;

  axi_full_m_refill_if #(.LINE_BEATS(LB)) bus ();

  axi_full_m_refill #(.LINE_BEATS(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          accept_cyc;
  int          last_beat_cyc;
  int          beats_acc;
  int          ar_hs_cnt;
  logic        ar_unstable;
  logic        ready_after;
  logic        prev_resp;
  logic [31:0] ar_addr_seen;
  logic [7:0]  ar_len_seen;
  logic [2:0]  ar_size_seen;
  logic [1:0]  ar_burst_seen;
  logic [63:0] model_line [LB];
  exp_t        exp_q [$];
  resp_t       resp_q [$];

  always #5 clk = ~clk;

  // Cycle counter: during cycle k (after the k-th rising edge) cyc equals k
  always @(posedge clk) cyc <= cyc + 1;

  // Observe the bus at each rising edge with the values of the cycle just ending
  always @(posedge clk) begin
    if (bus.resp_valid) resp_q.push_back('{line: bus.resp_line, err: bus.resp_err, cyc: cyc});
    if (bus.rvalid && bus.rready) begin
      beats_acc++;
      last_beat_cyc = cyc;
    end
    if (bus.arvalid && bus.arready) begin
      ar_hs_cnt++;
      ar_addr_seen  = bus.araddr;
      ar_len_seen   = bus.arlen;
      ar_size_seen  = bus.arsize;
      ar_burst_seen = bus.arburst;
    end
    if (prev_resp) ready_after = bus.req_ready;
    prev_resp = bus.resp_valid;
  end

  function automatic logic [63:0] beat_data(input logic [7:0] seed, input int b);
    logic [7:0] v;
    v = seed + 8'(8'h11 * (b + 1));
    return {8{v}};
  endfunction

  // Predict the line after a burst that writes slots 0..n_write-1
  task automatic push_expect(input int n_write, input logic [7:0] seed, input logic err);
    exp_t e;
    for (int b = 0; b < n_write; b++) model_line[b] = beat_data(seed, b);
    for (int i = 0; i < LB; i++) e.line[64*i +: 64] = model_line[i];
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Issue one request and play the memory slave for it
  task automatic do_burst(input logic [31:0] addr, input int ar_wait, input int gap,
                          input int n_offer, input int last_idx, input int bad_idx,
                          input logic [7:0] seed);
    int guard;
    logic [31:0] first_addr;
    ar_unstable = 1'b0;
    ready_after = 1'b0;
    beats_acc   = 0;
    ar_hs_cnt   = 0;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    accept_cyc    = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    guard = 0;
    while (bus.arvalid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    first_addr = bus.araddr;
    for (int k = 0; k < ar_wait; k++) begin
      @(negedge clk);
      if (bus.arvalid !== 1'b1 || bus.araddr !== first_addr) ar_unstable = 1'b1;
    end
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    for (int b = 0; b < n_offer; b++) begin
      if (b > 0) repeat (gap) @(negedge clk);
      bus.rvalid = 1'b1;
      bus.rdata  = beat_data(seed, b);
      bus.rresp  = (b == bad_idx) ? 2'b10 : 2'b00;
      bus.rlast  = (b == last_idx);
      guard = 0;
      while (bus.rready !== 1'b1 && guard < 8) begin @(negedge clk); guard++; end
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
      bus.rdata  = '0;
    end
    guard = 0;
    while (resp_q.size() == 0 && guard < 20) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid: got %b want 0", bus.arvalid); end
    n_cmp++; if (bus.rready !== 1'b0) begin n_err++; $display("FAIL reset_rready: got %b want 0", bus.rready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
    n_cmp++; if (bus.araddr !== 32'h0) begin n_err++; $display("FAIL reset_araddr: got %h want 0", bus.araddr); end
    n_cmp++; if (bus.resp_line !== '0) begin n_err++; $display("FAIL reset_resp_line: got %h want 0", bus.resp_line); end
    n_cmp++; if (bus.arburst !== 2'b01) begin n_err++; $display("FAIL reset_arburst: got %h want 1", bus.arburst); end
    n_cmp++; if (bus.arlen !== 8'd3) begin n_err++; $display("FAIL reset_arlen: got %h want 3", bus.arlen); end
    n_cmp++; if (bus.arsize !== 3'd3) begin n_err++; $display("FAIL reset_arsize: got %h want 3", bus.arsize); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL after_reset_req_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_normal;
    resp_t r;
    exp_t e;
    resp_q.delete();
    push_expect(4, 8'h00, 1'b0);
    do_burst(32'h8000_1234, 0, 0, 4, 3, -1, 8'h00);
    n_cmp++; if (ar_addr_seen !== 32'h8000_1220) begin n_err++; $display("FAIL normal_araddr: got %h want 80001220", ar_addr_seen); end
    n_cmp++; if (ar_len_seen !== 8'd3) begin n_err++; $display("FAIL normal_arlen: got %0d want 3", ar_len_seen); end
    n_cmp++; if (ar_size_seen !== 3'd3) begin n_err++; $display("FAIL normal_arsize: got %0d want 3", ar_size_seen); end
    n_cmp++; if (ar_burst_seen !== 2'd1) begin n_err++; $display("FAIL normal_arburst: got %0d want 1", ar_burst_seen); end
    n_cmp++;
    if (resp_q.size() !== 1) begin
      n_err++; $display("FAIL normal_resp_count: got %0d want 1", resp_q.size());
    end else begin
      r = resp_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.line !== e.line) begin n_err++; $display("FAIL normal_line: got %h want %h", r.line, e.line); end
      n_cmp++; if (r.err !== e.err) begin n_err++; $display("FAIL normal_err: got %b want %b", r.err, e.err); end
      n_cmp++; if (r.cyc - accept_cyc !== 6) begin n_err++; $display("FAIL normal_latency: got %0d want 6", r.cyc - accept_cyc); end
      n_cmp++; if (ready_after !== 1'b1) begin n_err++; $display("FAIL normal_ready_after_resp: got %b want 1", ready_after); end
    end
    exp_q.delete();
  endtask

  task automatic test_stall;
    resp_t r;
    exp_t e;
    resp_q.delete();
    push_expect(4, 8'h40, 1'b0);
    do_burst(32'h0000_003F, 3, 2, 4, 3, -1, 8'h40);
    n_cmp++; if (ar_unstable !== 1'b0) begin n_err++; $display("FAIL stall_ar_stable: got %b want 0", ar_unstable); end
    n_cmp++; if (ar_addr_seen !== 32'h0000_0020) begin n_err++; $display("FAIL stall_araddr: got %h want 00000020", ar_addr_seen); end
    n_cmp++; if (ar_hs_cnt !== 1) begin n_err++; $display("FAIL stall_ar_handshakes: got %0d want 1", ar_hs_cnt); end
    n_cmp++; if (beats_acc !== 4) begin n_err++; $display("FAIL stall_beats: got %0d want 4", beats_acc); end
    n_cmp++;
    if (resp_q.size() !== 1) begin
      n_err++; $display("FAIL stall_resp_count: got %0d want 1", resp_q.size());
    end else begin
      r = resp_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.line !== e.line) begin n_err++; $display("FAIL stall_line: got %h want %h", r.line, e.line); end
      n_cmp++; if (r.err !== e.err) begin n_err++; $display("FAIL stall_err: got %b want %b", r.err, e.err); end
    end
    exp_q.delete();
  endtask

  task automatic test_rresp_err;
    resp_t r;
    exp_t e;
    resp_q.delete();
    push_expect(4, 8'h80, 1'b1);
    do_burst(32'h1234_5678, 0, 0, 4, 3, 1, 8'h80);
    n_cmp++; if (beats_acc !== 4) begin n_err++; $display("FAIL rresp_beats: got %0d want 4", beats_acc); end
    n_cmp++;
    if (resp_q.size() !== 1) begin
      n_err++; $display("FAIL rresp_resp_count: got %0d want 1", resp_q.size());
    end else begin
      r = resp_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.line !== e.line) begin n_err++; $display("FAIL rresp_line: got %h want %h", r.line, e.line); end
      n_cmp++; if (r.err !== e.err) begin n_err++; $display("FAIL rresp_err: got %b want %b", r.err, e.err); end
    end
    exp_q.delete();
  endtask

  task automatic test_early_rlast;
    resp_t r;
    exp_t e;
    resp_q.delete();
    push_expect(2, 8'hC0, 1'b1);
    do_burst(32'h0000_1000, 0, 0, 2, 1, -1, 8'hC0);
    n_cmp++; if (beats_acc !== 2) begin n_err++; $display("FAIL early_beats: got %0d want 2", beats_acc); end
    n_cmp++;
    if (resp_q.size() !== 1) begin
      n_err++; $display("FAIL early_resp_count: got %0d want 1", resp_q.size());
    end else begin
      r = resp_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.line !== e.line) begin n_err++; $display("FAIL early_line: got %h want %h", r.line, e.line); end
      n_cmp++; if (r.err !== e.err) begin n_err++; $display("FAIL early_err: got %b want %b", r.err, e.err); end
      n_cmp++; if (r.cyc - last_beat_cyc !== 1) begin n_err++; $display("FAIL early_resp_timing: got %0d want 1", r.cyc - last_beat_cyc); end
    end
    exp_q.delete();
  endtask

  task automatic test_missing_rlast;
    resp_t r;
    exp_t e;
    resp_q.delete();
    push_expect(4, 8'h05, 1'b1);
    do_burst(32'h0000_2040, 0, 0, 5, -1, -1, 8'h05);
    n_cmp++; if (beats_acc !== 4) begin n_err++; $display("FAIL missing_beats: got %0d want 4", beats_acc); end
    n_cmp++; if (bus.rready !== 1'b0) begin n_err++; $display("FAIL missing_rready_after: got %b want 0", bus.rready); end
    n_cmp++;
    if (resp_q.size() !== 1) begin
      n_err++; $display("FAIL missing_resp_count: got %0d want 1", resp_q.size());
    end else begin
      r = resp_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.line !== e.line) begin n_err++; $display("FAIL missing_line: got %h want %h", r.line, e.line); end
      n_cmp++; if (r.err !== e.err) begin n_err++; $display("FAIL missing_err: got %b want %b", r.err, e.err); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst;
    resp_t r;
    exp_t e;
    resp_q.delete();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_3000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.arready   = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = beat_data(8'h99, b);
      bus.rlast  = 1'b0;
      if (b == 2) rst = 1'b1;
      @(negedge clk);
    end
    rst        = 1'b0;
    bus.rvalid = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL midrst_arvalid: got %b want 0", bus.arvalid); end
    n_cmp++; if (bus.rready !== 1'b0) begin n_err++; $display("FAIL midrst_rready: got %b want 0", bus.rready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_line !== '0) begin n_err++; $display("FAIL midrst_resp_line: got %h want 0", bus.resp_line); end
    repeat (4) @(negedge clk);
    n_cmp++; if (resp_q.size() !== 0) begin n_err++; $display("FAIL midrst_no_resp: got %0d want 0", resp_q.size()); end
    resp_q.delete();
    for (int i = 0; i < LB; i++) model_line[i] = '0;
    push_expect(4, 8'h33, 1'b0);
    do_burst(32'hABCD_EF01, 0, 0, 4, 3, -1, 8'h33);
    n_cmp++; if (ar_addr_seen !== 32'hABCD_EF00) begin n_err++; $display("FAIL midrst_next_araddr: got %h want abcdef00", ar_addr_seen); end
    n_cmp++;
    if (resp_q.size() !== 1) begin
      n_err++; $display("FAIL midrst_next_resp_count: got %0d want 1", resp_q.size());
    end else begin
      r = resp_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.line !== e.line) begin n_err++; $display("FAIL midrst_next_line: got %h want %h", r.line, e.line); end
      n_cmp++; if (r.err !== e.err) begin n_err++; $display("FAIL midrst_next_err: got %b want %b", r.err, e.err); end
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    prev_resp     = 1'b0;
    ready_after   = 1'b0;
    beats_acc     = 0;
    ar_hs_cnt     = 0;
    last_beat_cyc = 0;
    accept_cyc    = 0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    bus.rlast     = 1'b0;
    for (int i = 0; i < LB; i++) model_line[i] = '0;

    test_reset();
    test_normal();
    test_stall();
    test_rresp_err();
    test_early_rlast();
    test_missing_rlast();
    test_reset_mid_burst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
